// File: rtl/reg_encoder_pkg.sv
// reg_encoder_pkg
// Shared constants and types for the register-mask encoder.
//   NUM_REGS  : number of registers / mask width
//   IDX_W     : width of a register index
//   state_t   : encoder control states (OCIOSO, EMITE, FIM)
//   MASK_ZERO : the empty register mask
package reg_encoder_pkg;

    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        EMITE  = 2'd1,
        FIM    = 2'd2
    } state_t;

    localparam logic [NUM_REGS-1:0] MASK_ZERO = '0;

endpackage

// File: rtl/prio_enc8.sv
// prio_enc8
// Combinational 8-to-3 priority encoder with selectable direction.
//   vec_i  : input vector
//   desc_i : 0 = lowest set bit wins, 1 = highest set bit wins
//   idx_o  : index of the winning bit (0 when vec_i is zero)
//   any_o  : at least one bit of vec_i is set
module prio_enc8
    import reg_encoder_pkg::*;
(
    input  logic [NUM_REGS-1:0] vec_i,
    input  logic                desc_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic                any_o
);

    // The scan runs towards the preferred end so that the last match
    // written is the winner.
    always_comb begin
        idx_o = '0;
        if (desc_i) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (vec_i[k]) begin
                    idx_o = IDX_W'(k);
                end
            end
        end else begin
            for (int k = NUM_REGS - 1; k >= 0; k--) begin
                if (vec_i[k]) begin
                    idx_o = IDX_W'(k);
                end
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/reg_encoder.sv
// reg_encoder
// Sequential register-mask encoder: emits the index of every set bit of a
// loaded 8-bit register mask, one index per valid/ready handshake.
// Optional feature macro: REG_ENCODER_DESC_EN adds the `descendente` input
// (1 = highest register first); without it the order is always ascending.
// Ports:
//   clock       : rising-edge clock
//   resetn      : asynchronous active-low reset
//   carga       : load pulse, accepted only when idle
//   mascara     : register mask (bit k = register rk)
//   descendente : order select, latched on load (REG_ENCODER_DESC_EN only)
//   ocupado     : mask being served
//   out_valid   : indice is valid
//   out_ready   : consumer accepts indice
//   indice      : index of the current pending register
//   fim         : one-cycle pulse after the last index
//   contagem    : indices accepted since the last load
module reg_encoder
    import reg_encoder_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic                carga,
    input  logic [NUM_REGS-1:0] mascara,
`ifdef REG_ENCODER_DESC_EN
    input  logic                descendente,
`endif
    output logic                ocupado,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    indice,
    output logic                fim,
    output logic [3:0]          contagem
);

    state_t              state_q;
    logic [NUM_REGS-1:0] pendente_q;
    logic [NUM_REGS-1:0] pendente_d;
    logic [3:0]          contagem_q;
    logic [3:0]          contagem_d;
    logic                descSel;
    logic [IDX_W-1:0]    selIdx;
    logic                selAny;
    logic [IDX_W-1:0]    oppIdx;
    logic                oppAny;
    logic                handshake;
    logic                lastBit;

`ifdef REG_ENCODER_DESC_EN
    logic desc_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            desc_q <= 1'b0;
        end else if (state_q == OCIOSO && carga) begin
            desc_q <= descendente;
        end
    end

    assign descSel = desc_q;
`else
    assign descSel = 1'b0;
`endif

    // selEnc picks the bit to emit; oppEnc scans from the other end. When
    // both ends land on the same bit, exactly one bit is left pending.
    prio_enc8 selEnc (
        .vec_i  (pendente_q),
        .desc_i (descSel),
        .idx_o  (selIdx),
        .any_o  (selAny)
    );

    prio_enc8 oppEnc (
        .vec_i  (pendente_q),
        .desc_i (~descSel),
        .idx_o  (oppIdx),
        .any_o  (oppAny)
    );

    assign out_valid  = (state_q == EMITE) && selAny;
    assign indice     = out_valid ? selIdx : '0;
    assign ocupado    = (state_q == EMITE);
    assign fim        = (state_q == FIM);
    assign contagem   = contagem_q;

    assign handshake  = out_valid && out_ready;
    assign lastBit    = oppAny && (selIdx == oppIdx);
    assign pendente_d = pendente_q & ~(NUM_REGS'(1) << selIdx);
    assign contagem_d = contagem_q + 4'd1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= OCIOSO;
            pendente_q <= MASK_ZERO;
            contagem_q <= '0;
        end else begin
            case (state_q)
                OCIOSO: begin
                    if (carga) begin
                        pendente_q <= mascara;
                        contagem_q <= '0;
                        state_q    <= (mascara == MASK_ZERO) ? FIM : EMITE;
                    end
                end
                EMITE: begin
                    if (handshake) begin
                        pendente_q <= pendente_d;
                        contagem_q <= contagem_d;
                        if (lastBit) begin
                            state_q <= FIM;
                        end
                    end
                end
                FIM: begin
                    state_q <= OCIOSO;
                end
                default: begin
                    state_q <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_encoder.sv
// tb_reg_encoder
// Self-checking bench for reg_encoder. A queue of expected indices is built
// straight from each mask and popped on every accepted handshake.
// Honours REG_ENCODER_DESC_EN to exercise the descending order.
module tb_reg_encoder;

    logic       clock;
    logic       resetn;
    logic       carga;
    logic [7:0] mascara;
    logic       ocupado;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] indice;
    logic       fim;
    logic [3:0] contagem;
    logic       descendente;

    int testCount;
    int failCount;

    reg_encoder dut (
        .clock       (clock),
        .resetn      (resetn),
        .carga       (carga),
        .mascara     (mascara),
`ifdef REG_ENCODER_DESC_EN
        .descendente (descendente),
`endif
        .ocupado     (ocupado),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .indice      (indice),
        .fim         (fim),
        .contagem    (contagem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Loads one mask and serves it; glitchAt injects a carga pulse with
    // mask 8'h01 at that service cycle, toggleDesc flips descendente.
    task automatic applyStimulus(input logic [7:0] mask, input bit desc,
                                 input bit randReady, input int glitchAt,
                                 input bit toggleDesc);
        int expQ[$];
        int served;
        int stall;
        bit done;
        @(negedge clock);
        carga       = 1'b1;
        mascara     = mask;
        descendente = desc;
        out_ready   = 1'b0;
        @(negedge clock);
        carga   = 1'b0;
        mascara = 8'($urandom);
        expQ.delete();
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) begin
`ifdef REG_ENCODER_DESC_EN
                if (desc) expQ.push_front(k);
                else      expQ.push_back(k);
`else
                expQ.push_back(k);
`endif
            end
        end
        served = 0;
        stall  = 0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            carga = (cyc == glitchAt);
            if (cyc == glitchAt) mascara = 8'h01;
            if (toggleDesc) descendente = ~descendente;
            out_ready = randReady ? ((stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
            if (expQ.size() > 0) begin
                checkOutput("valid",    {7'd0, out_valid}, 8'd1);
                checkOutput("ocupado",  {7'd0, ocupado},   8'd1);
                checkOutput("fimLow",   {7'd0, fim},       8'd0);
                checkOutput("indice",   {5'd0, indice},    8'(expQ[0]));
                checkOutput("contagem", {4'd0, contagem},  8'(served));
                if (out_ready) begin
                    void'(expQ.pop_front());
                    served++;
                    stall = 0;
                end else begin
                    stall++;
                end
            end else begin
                checkOutput("fimPulse", {7'd0, fim},       8'd1);
                checkOutput("validEnd", {7'd0, out_valid}, 8'd0);
                checkOutput("ocupEnd",  {7'd0, ocupado},   8'd0);
                checkOutput("idxEnd",   {5'd0, indice},    8'd0);
                checkOutput("cntEnd",   {4'd0, contagem},  8'(served));
                done = 1'b1;
            end
            @(negedge clock);
        end
        carga = 1'b0;
        if (!done) checkOutput("timeout", 8'd0, 8'd1);
        checkOutput("idleFim",  {7'd0, fim},      8'd0);
        checkOutput("idleOcup", {7'd0, ocupado},  8'd0);
        checkOutput("idleCnt",  {4'd0, contagem}, 8'(served));
    endtask

    initial begin
        testCount   = 0;
        failCount   = 0;
        resetn      = 1'b0;
        carga       = 1'b0;
        mascara     = 8'h00;
        out_ready   = 1'b0;
        descendente = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("rstValid", {7'd0, out_valid}, 8'd0);
        checkOutput("rstOcup",  {7'd0, ocupado},   8'd0);
        checkOutput("rstFim",   {7'd0, fim},       8'd0);
        checkOutput("rstCnt",   {4'd0, contagem},  8'd0);
        resetn = 1'b1;

        applyStimulus(8'b1010_0110, 1'b0, 1'b0, -1, 1'b0);
        applyStimulus(8'b1010_0110, 1'b0, 1'b1, -1, 1'b0);
        applyStimulus(8'h00,        1'b0, 1'b0, -1, 1'b0);
        applyStimulus(8'hFF,        1'b0, 1'b0,  2, 1'b0);
        applyStimulus(8'h80,        1'b0, 1'b1, -1, 1'b0);
        applyStimulus(8'h01,        1'b0, 1'b1, -1, 1'b0);

        // Reset in the middle of 8'hF0 after two accepted indices.
        @(negedge clock);
        carga     = 1'b1;
        mascara   = 8'hF0;
        out_ready = 1'b1;
        @(negedge clock);
        carga = 1'b0;
        checkOutput("rsIdx0", {5'd0, indice}, 8'd4);
        @(negedge clock);
        checkOutput("rsIdx1", {5'd0, indice}, 8'd5);
        @(negedge clock);
        checkOutput("rsCnt2", {4'd0, contagem}, 8'd2);
        resetn = 1'b0;
        #1;
        checkOutput("rsValid", {7'd0, out_valid}, 8'd0);
        checkOutput("rsOcup",  {7'd0, ocupado},   8'd0);
        checkOutput("rsFim",   {7'd0, fim},       8'd0);
        checkOutput("rsIdx",   {5'd0, indice},    8'd0);
        checkOutput("rsCnt",   {4'd0, contagem},  8'd0);
        @(negedge clock);
        resetn = 1'b1;
        applyStimulus(8'h08, 1'b0, 1'b0, -1, 1'b0);

`ifdef REG_ENCODER_DESC_EN
        applyStimulus(8'b0100_1001, 1'b1, 1'b0, -1, 1'b0);
        applyStimulus(8'b0100_1001, 1'b1, 1'b1, -1, 1'b1);
        applyStimulus(8'b0100_1001, 1'b0, 1'b1, -1, 1'b1);
`endif

        for (int n = 0; n < 20; n++) begin
            applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/reg_encoder.md
# reg_encoder

Sequential register-mask encoder: the inverse of the processor's 3-to-8 register decoder. It accepts an 8-bit register mask (one bit per r0..r7, e.g. the register list of a multi-register push/pop instruction) and emits the 3-bit index of each set bit, one per valid/ready handshake. It sits between the instruction control unit and the register-file select path, where each emitted index drives the existing decoder.

## Interface
Parameters:
- NUM_REGS, 8, number of registers / mask width (fixed at 8 in this revision)
- IDX_W, 3, index width, log2(NUM_REGS)

Ports:
- clock  in  1  single clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- carga  in  1  load pulse; captures `mascara` when idle
- mascara  in  8  register mask; bit k = register rk
- ocupado  out  1  high from the cycle after an accepted load until `fim` is asserted
- out_valid  out  1  `indice` is valid
- out_ready  in  1  consumer accepts `indice`
- indice  out  3  register index of the current pending bit
- fim  out  1  one-cycle pulse: mask fully served
- contagem  out  4  number of indices accepted since the last load (0..8)
- descendente  in  1  order select; present only with REG_ENCODER_DESC_EN

## Operation
- State machine (3 states): OCIOSO, EMITE, FIM.
- OCIOSO: when `carga`=1, the block latches `mascara` into `pendente`, clears `contagem`, and sets `ocupado`=1.
  - Non-zero mask -> EMITE.
  - Zero mask -> FIM. `fim` pulses and no index is emitted.
- EMITE: `out_valid`=1; `indice` = selected set bit of `pendente`.
  - Ascending order (default): lowest set bit.
  - Descending order: highest set bit.
- Handshake = `out_valid` & `out_ready`. On a handshake:
  - clear that bit of `pendente`;
  - `contagem` += 1;
  - if `pendente` becomes zero -> FIM.
- While `out_ready`=0, `indice` and `out_valid` hold stable (no retraction).
- FIM: `fim`=1 for exactly one cycle, `ocupado`=0, `out_valid`=0 -> OCIOSO. `contagem` holds its final value until the next accepted load.
- `carga` in EMITE or FIM is ignored. No re-latch; `pendente` is unaffected.
- `mascara` is sampled only on the accepted load cycle.
- `indice` is 0 whenever `out_valid`=0.
- Reset (any time, including mid-mask):
  - state=OCIOSO, `pendente`=0, `contagem`=0;
  - `ocupado`=0, `out_valid`=0, `fim`=0, `indice`=0;
  - the partially served mask is discarded.

## Timing
- Load in cycle N -> `out_valid`=1 in cycle N+1 (or `fim`=1 in N+1 for a zero mask).
- One index per cycle at most. With `out_ready` held high, a mask with k set bits:
  - indices in cycles N+1..N+k;
  - `fim` in N+k+1;
  - back in OCIOSO, accepting load, in N+k+2.
- `indice`, `out_valid`, `ocupado`, `fim` and `contagem` are all registered-state functions. `indice` is combinational from `pendente` and the order select only, with no path from `out_ready`.
- `contagem` updates in the cycle after the handshake.

## Configuration
- REG_ENCODER_DESC_EN defined:
  - the `descendente` port exists;
  - its value is sampled together with `mascara` on load and held for the whole mask;
  - 1 = highest bit first.
- Not defined: the port is absent and the order is always ascending.

## Structure
- Package `reg_encoder_pkg`:
  - NUM_REGS=8, IDX_W=3;
  - state encoding for OCIOSO/EMITE/FIM (2-bit);
  - constant for the zero mask.
- Sub-module `prio_enc8`: combinational 8-bit to 3-bit priority encoder with a direction input and an "any bit set" output. It is used for `indice` selection and for the last-bit detection.

## Test plan
- Reset, then load mascara=8'b1010_0110 with out_ready=1 -> indices 1,2,5,7 in consecutive cycles, then fim pulse, contagem=4.
- Same mask with out_ready toggling 1,0,0,1,... -> indice holds while stalled, order 1,2,5,7, no index repeated or skipped.
- Load mascara=8'h00 -> fim in the next cycle, out_valid never 1, contagem=0.
- Load 8'hFF, then pulse carga with 8'h01 during EMITE -> ignored; all 8 indices 0..7 are emitted, contagem=8.
- Load 8'hF0, then assert resetn=0 after two handshakes -> all outputs 0 immediately. After release, load 8'h08 -> single index 3.
- With REG_ENCODER_DESC_EN: load 8'b0100_1001 with descendente=1 -> indices 6,3,0. Toggling descendente mid-mask does not change the order.
